// File: rtl/core_insn_fetch_buffer_if.sv
// ----------------------------------------------------------------------------
// core_insn_fetch_buffer_if
// Bundles the scheduler load bus and the pipeline fetch handshake of one
// core's instruction fetch buffer.
//   start, insn_load_counter, insn_data, init_r0_en, init_r0 : scheduler -> buffer
//   ready                                                    : buffer -> scheduler
//   fetch_valid, fetch_insn, fetch_pc, r0_load, r0_value     : buffer -> pipeline
//   fetch_accept, halt                                       : pipeline -> buffer
// Modports: master = scheduler/pipeline side, slave = fetch buffer side.
// ----------------------------------------------------------------------------
interface core_insn_fetch_buffer_if #(
   parameter int INSN_W = 16,
   parameter int CNT_W  = 3,
   parameter int REG_W  = 8,
   parameter int PC_W   = 6
);
   logic              start;
   logic [CNT_W-1:0]  insn_load_counter;
   logic [INSN_W-1:0] insn_data;
   logic              init_r0_en;
   logic [REG_W-1:0]  init_r0;
   logic              ready;
   logic              fetch_valid;
   logic [INSN_W-1:0] fetch_insn;
   logic [PC_W-1:0]   fetch_pc;
   logic              fetch_accept;
   logic              halt;
   logic              r0_load;
   logic [REG_W-1:0]  r0_value;

   modport master (
      output start, insn_load_counter, insn_data, init_r0_en, init_r0,
             fetch_accept, halt,
      input  ready, fetch_valid, fetch_insn, fetch_pc, r0_load, r0_value
   );

   modport slave (
      input  start, insn_load_counter, insn_data, init_r0_en, init_r0,
             fetch_accept, halt,
      output ready, fetch_valid, fetch_insn, fetch_pc, r0_load, r0_value
   );
endinterface

// File: rtl/core_insn_fetch_buffer.sv
// ----------------------------------------------------------------------------
// core_insn_fetch_buffer
// Per-core front end behind the task scheduler. While Start is high the
// streamed instruction parts are captured into a local buffer (and R0's
// initial value is latched); once Start drops, the buffered words are handed
// to the core pipeline over a valid/accept handshake, then the block idles.
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   bus          core_insn_fetch_buffer_if.slave (scheduler + pipeline signals)
//   overflow     sticky: a part addressed beyond the buffer depth was offered
//   protocol_err sticky: Start seen while executing
//   exec_cycles  (only with macro IFB_CYCLE_CNT_EN) saturating count of
//                cycles spent in the last/current execution phase
// ----------------------------------------------------------------------------
module core_insn_fetch_buffer #(
   parameter int INSN_W = 16,
   parameter int PARTS  = 8,
   parameter int CNT_W  = 3,
   parameter int DEPTH  = 64,
   parameter int REG_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   core_insn_fetch_buffer_if.slave bus,
   output logic                   overflow,
   output logic                   protocol_err
`ifdef IFB_CYCLE_CNT_EN
   ,
   output logic [15:0]            exec_cycles
`endif
);
   localparam int PC_W   = $clog2(DEPTH);
   // Two spare bits so frame_base + part index can exceed DEPTH without wrapping.
   localparam int ADDR_W = PC_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC} state_t;

   state_t            state;
   logic [INSN_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] frame_base;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en;
   logic              r0_en_r;
   logic              ready_q;
   logic              fetch_valid_q;
   logic              r0_load_q;
   logic [INSN_W-1:0] fetch_insn_q;
   logic [PC_W-1:0]   fetch_pc_q;
   logic [REG_W-1:0]  r0_value_q;

   // The first part of a task always lands in word 0; later parts are placed
   // relative to the current frame. Anything past the buffer end is dropped.
   assign wr_addr = (state == S_IDLE) ? '0
                                      : frame_base + ADDR_W'(bus.insn_load_counter);
   assign wr_en   = bus.start && (state != S_EXEC) && (wr_addr < ADDR_W'(DEPTH));
   assign pc_inc  = pc + ADDR_W'(1);

   // Buffer storage has no reset; stale contents beyond the word count are
   // never presented to the pipeline.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr[PC_W-1:0]] <= bus.insn_data;
      end
   end

   // Main sequencer: IDLE waits for Start, LOAD tracks frame base and word
   // count, EXEC walks pc through the buffer with a registered read so the
   // presented word and its pc hold still until the pipeline accepts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         frame_base    <= '0;
         count         <= '0;
         pc            <= '0;
         r0_en_r       <= 1'b0;
         ready_q       <= 1'b1;
         fetch_valid_q <= 1'b0;
         fetch_insn_q  <= '0;
         fetch_pc_q    <= '0;
         r0_load_q     <= 1'b0;
         r0_value_q    <= '0;
         overflow      <= 1'b0;
         protocol_err  <= 1'b0;
      end else begin
         r0_load_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state      <= S_LOAD;
                  frame_base <= '0;
                  count      <= ADDR_W'(1);
                  r0_en_r    <= bus.init_r0_en;
                  if (bus.init_r0_en) begin
                     r0_value_q <= bus.init_r0;
                  end
               end
            end
            S_LOAD: begin
               if (bus.start) begin
                  if (wr_addr >= ADDR_W'(DEPTH)) begin
                     overflow <= 1'b1;
                     count    <= ADDR_W'(DEPTH);
                  end else if ((wr_addr + ADDR_W'(1)) > count) begin
                     count <= wr_addr + ADDR_W'(1);
                  end
                  // Once the base reaches the end it stops, so later frames
                  // keep addressing past DEPTH and are all dropped.
                  if ((bus.insn_load_counter == CNT_W'(PARTS - 1)) &&
                      (frame_base < ADDR_W'(DEPTH))) begin
                     frame_base <= frame_base + ADDR_W'(PARTS);
                  end
               end else begin
                  state         <= S_EXEC;
                  ready_q       <= 1'b0;
                  pc            <= '0;
                  fetch_valid_q <= 1'b1;
                  fetch_insn_q  <= mem[0];
                  fetch_pc_q    <= '0;
                  r0_load_q     <= r0_en_r;
               end
            end
            S_EXEC: begin
               if (bus.start) begin
                  protocol_err <= 1'b1;
               end
               // Halt wins over a simultaneous accept.
               if (bus.halt) begin
                  state         <= S_IDLE;
                  ready_q       <= 1'b1;
                  fetch_valid_q <= 1'b0;
               end else if (bus.fetch_accept) begin
                  if (pc_inc < count) begin
                     pc           <= pc_inc;
                     fetch_insn_q <= mem[pc_inc[PC_W-1:0]];
                     fetch_pc_q   <= pc_inc[PC_W-1:0];
                  end else begin
                     state         <= S_IDLE;
                     ready_q       <= 1'b1;
                     fetch_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_insn  = fetch_insn_q;
   assign bus.fetch_pc    = fetch_pc_q;
   assign bus.r0_load     = r0_load_q;
   assign bus.r0_value    = r0_value_q;

`ifdef IFB_CYCLE_CNT_EN
   // Counts every cycle spent in EXEC; restarts on the LOAD->EXEC edge and
   // freezes outside EXEC so software can read the last task's length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exec_cycles <= '0;
      end else if ((state == S_LOAD) && !bus.start) begin
         exec_cycles <= '0;
      end else if ((state == S_EXEC) && (exec_cycles != 16'hFFFF)) begin
         exec_cycles <= exec_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_core_insn_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_core_insn_fetch_buffer
// Self-checking bench for core_insn_fetch_buffer: a cycle table for a short
// task, hand-written tasks for the multi-cycle corner cases and randomized
// tasks checked against a word-list model of what the buffer should hold.
// Honours macro IFB_CYCLE_CNT_EN to also check exec_cycles.
// ----------------------------------------------------------------------------
module tb_core_insn_fetch_buffer;
   localparam int INSN_W = 16;
   localparam int PARTS  = 8;
   localparam int CNT_W  = 3;
   localparam int DEPTH  = 64;
   localparam int REG_W  = 8;
   localparam int PC_W   = 6;

   logic clk;
   logic reset;
   logic overflow;
   logic protocol_err;
`ifdef IFB_CYCLE_CNT_EN
   logic [15:0] exec_cycles;
`endif

   core_insn_fetch_buffer_if #(.INSN_W(INSN_W), .CNT_W(CNT_W), .REG_W(REG_W), .PC_W(PC_W)) bus ();

   core_insn_fetch_buffer #(
      .INSN_W(INSN_W), .PARTS(PARTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .REG_W(REG_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .overflow(overflow),
      .protocol_err(protocol_err)
`ifdef IFB_CYCLE_CNT_EN
      ,
      .exec_cycles(exec_cycles)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [2:0]  cnt;
      logic [15:0] data;
      logic        r0en;
      logic [7:0]  r0;
      logic        accept;
      logic        halt;
      logic        exp_ready;
      logic        exp_valid;
      logic        chk_fetch;
      logic [5:0]  exp_pc;
      logic [15:0] exp_insn;
      logic        exp_r0_load;
      logic [7:0]  exp_r0_val;
      logic        exp_perr;
   } vec_t;

   vec_t        vecs [9];
   int          checks;
   int          failures;
   logic [15:0] part_data [128];
   logic [15:0] mem_model [DEPTH];
   int          cnt_model;
   logic [7:0]  r0_model;
   bit          r0en_model;
   bit          ovf_model;

   // Compare one observed value against the bench's own expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the scheduler/pipeline inputs of one table row.
   task automatic applyStimulus(input vec_t v);
      bus.start             = v.start;
      bus.insn_load_counter = v.cnt;
      bus.insn_data         = v.data;
      bus.init_r0_en        = v.r0en;
      bus.init_r0           = v.r0;
      bus.fetch_accept      = v.accept;
      bus.halt              = v.halt;
   endtask

   task automatic idleInputs();
      bus.start             = 1'b0;
      bus.insn_load_counter = '0;
      bus.insn_data         = '0;
      bus.init_r0_en        = 1'b0;
      bus.init_r0           = '0;
      bus.fetch_accept      = 1'b0;
      bus.halt              = 1'b0;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_ready", bus.ready, 1);
      checkOutput("rst_valid", bus.fetch_valid, 0);
      checkOutput("rst_r0_load", bus.r0_load, 0);
      checkOutput("rst_r0_value", bus.r0_value, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_perr", protocol_err, 0);
      checkOutput("rst_pc", bus.fetch_pc, 0);
      checkOutput("rst_insn", bus.fetch_insn, 0);
`ifdef IFB_CYCLE_CNT_EN
      checkOutput("rst_exec_cycles", exec_cycles, 0);
`endif
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      #2;
      checkResetValues();
      reset = 1'b1;
      r0_model  = '0;
      ovf_model = 1'b0;
      tick();
   endtask

   // Stream n parts from part_data as consecutive frames, then drop Start.
   // The model simply records part i at word i; words past DEPTH are lost.
   task automatic loadPhase(input int n, input bit r0en, input logic [7:0] r0v);
      checkOutput("ready_idle", bus.ready, 1);
      for (int i = 0; i < n; i++) begin
         bus.start             = 1'b1;
         bus.insn_load_counter = 3'(i % PARTS);
         bus.insn_data         = part_data[i];
         bus.init_r0_en        = r0en;
         bus.init_r0           = r0v;
         tick();
         checkOutput("ready_load", bus.ready, 1);
         checkOutput("valid_load", bus.fetch_valid, 0);
         if (i < DEPTH) mem_model[i] = part_data[i];
         else           ovf_model    = 1'b1;
      end
      if (r0en) r0_model = r0v;
      r0en_model = r0en;
      cnt_model  = (n < DEPTH) ? n : DEPTH;
      bus.start      = 1'b0;
      bus.init_r0_en = 1'b0;
      tick();
   endtask

   // Drain the buffer. acc_mode: 0 always accept, 1 pattern 1,0,0,1,
   // 2 every other cycle starting with 0, 3 random. halt_at >= 0 halts
   // (with a simultaneous accept) when that word is presented.
   task automatic execPhase(input int acc_mode, input int halt_at, output int iters);
      int idx;
      bit done;
      bit acc;
      bit hlt;
      idx   = 0;
      iters = 0;
      done  = 1'b0;
      while (!done && iters < 400) begin
         if (!bus.fetch_valid) begin
            done = 1'b1;
            checkOutput("ready_after_exec", bus.ready, 1);
         end else begin
            checkOutput("ready_exec", bus.ready, 0);
            checkOutput("fetch_pc", bus.fetch_pc, 32'(idx % DEPTH));
            checkOutput("fetch_insn", bus.fetch_insn, mem_model[idx % DEPTH]);
            checkOutput("r0_load", bus.r0_load, (iters == 0) ? 32'(r0en_model) : 0);
            if (iters == 0) checkOutput("r0_value", bus.r0_value, r0_model);
            case (acc_mode)
               0:       acc = 1'b1;
               1:       acc = (iters % 4 == 0) || (iters % 4 == 3);
               2:       acc = (iters % 2 == 1);
               default: acc = 1'($urandom_range(0, 1));
            endcase
            hlt = (idx == halt_at);
            if (hlt) acc = 1'b1;
            bus.fetch_accept = acc;
            bus.halt         = hlt;
            tick();
            iters++;
            if (hlt) begin
               done = 1'b1;
               checkOutput("halt_valid", bus.fetch_valid, 0);
               checkOutput("halt_ready", bus.ready, 1);
            end else if (acc) begin
               idx++;
            end
         end
      end
      bus.fetch_accept = 1'b0;
      bus.halt         = 1'b0;
      checkOutput("exec_timeout", done, 1);
      checkOutput("words_fetched", idx, (halt_at >= 0) ? halt_at : cnt_model);
      checkOutput("overflow", overflow, ovf_model);
      checkOutput("perr", protocol_err, 0);
`ifdef IFB_CYCLE_CNT_EN
      checkOutput("exec_cycles", exec_cycles, iters);
`endif
   endtask

   task automatic runTask(input int n, input bit r0en, input logic [7:0] r0v,
                          input int acc_mode, input int halt_at, output int iters);
      loadPhase(n, r0en, r0v);
      execPhase(acc_mode, halt_at, iters);
      tick();
   endtask

   initial begin
      int iters;
      int n;
      int cap;
      checks     = 0;
      failures   = 0;
      r0_model   = '0;
      r0en_model = 1'b0;
      ovf_model  = 1'b0;
      cnt_model  = 0;
      idleInputs();

      // Short task as a cycle table: 3 parts, R0 init, backpressure, a
      // stray Start while executing.
      vecs[0] = '{1, 3'd0, 16'hA000, 1, 8'h3C, 0, 0, 1, 0, 0, 6'd0, 16'h0000, 0, 8'h3C, 0};
      vecs[1] = '{1, 3'd1, 16'hA001, 0, 8'h00, 0, 0, 1, 0, 0, 6'd0, 16'h0000, 0, 8'h3C, 0};
      vecs[2] = '{1, 3'd2, 16'hA002, 0, 8'h00, 0, 0, 1, 0, 0, 6'd0, 16'h0000, 0, 8'h3C, 0};
      vecs[3] = '{0, 3'd0, 16'h0000, 0, 8'h00, 0, 0, 0, 1, 1, 6'd0, 16'hA000, 1, 8'h3C, 0};
      vecs[4] = '{0, 3'd0, 16'h0000, 0, 8'h00, 0, 0, 0, 1, 1, 6'd0, 16'hA000, 0, 8'h3C, 0};
      vecs[5] = '{0, 3'd0, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 1, 6'd1, 16'hA001, 0, 8'h3C, 0};
      vecs[6] = '{1, 3'd0, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 1, 6'd2, 16'hA002, 0, 8'h3C, 1};
      vecs[7] = '{0, 3'd0, 16'h0000, 0, 8'h00, 1, 0, 1, 0, 0, 6'd0, 16'h0000, 0, 8'h3C, 1};
      vecs[8] = '{0, 3'd0, 16'h0000, 0, 8'h00, 0, 0, 1, 0, 0, 6'd0, 16'h0000, 0, 8'h3C, 1};

      // Reset is asserted from time 0; outputs must already be at reset values.
      reset = 1'b0;
      #12;
      checkResetValues();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput("tbl_ready", bus.ready, vecs[i].exp_ready);
         checkOutput("tbl_valid", bus.fetch_valid, vecs[i].exp_valid);
         checkOutput("tbl_r0_load", bus.r0_load, vecs[i].exp_r0_load);
         checkOutput("tbl_r0_value", bus.r0_value, vecs[i].exp_r0_val);
         checkOutput("tbl_perr", protocol_err, vecs[i].exp_perr);
         if (vecs[i].chk_fetch) begin
            checkOutput("tbl_pc", bus.fetch_pc, vecs[i].exp_pc);
            checkOutput("tbl_insn", bus.fetch_insn, vecs[i].exp_insn);
         end
      end
      idleInputs();
      pulseReset();

      // Single frame, always accepting.
      for (int i = 0; i < 128; i++) part_data[i] = 16'h0100 + 16'(i);
      runTask(8, 1'b0, 8'h00, 0, -1, iters);

      // Two frames with R0 initialisation.
      for (int i = 0; i < 128; i++) part_data[i] = 16'($urandom);
      runTask(16, 1'b1, 8'hA5, 0, -1, iters);

      // Backpressure pattern 1,0,0,1.
      for (int i = 0; i < 128; i++) part_data[i] = 16'($urandom);
      runTask(8, 1'b0, 8'h00, 1, -1, iters);

      // Halt at pc 3, then a fresh 8-part task must refetch from pc 0.
      for (int i = 0; i < 128; i++) part_data[i] = 16'h2200 + 16'(i);
      runTask(8, 1'b0, 8'h00, 0, 3, iters);
      for (int i = 0; i < 128; i++) part_data[i] = 16'h3300 + 16'(i);
      runTask(8, 1'b0, 8'h00, 0, -1, iters);

      // Accept every other cycle: 8 words take 16 execution cycles.
      runTask(8, 1'b0, 8'h00, 2, -1, iters);
      checkOutput("alt_exec_iters", iters, 16);
`ifdef IFB_CYCLE_CNT_EN
      checkOutput("alt_exec_cycles", exec_cycles, 16);
`endif

      // Nine frames overflow a 64-word buffer.
      for (int i = 0; i < 128; i++) part_data[i] = 16'($urandom);
      runTask(72, 1'b0, 8'h00, 0, -1, iters);
      checkOutput("overflow_sticky", overflow, 1);

      // Reset in the middle of an execution phase, away from a clock edge.
      for (int i = 0; i < 128; i++) part_data[i] = 16'($urandom);
      loadPhase(8, 1'b1, 8'h5A);
      checkOutput("pre_reset_valid", bus.fetch_valid, 1);
      bus.fetch_accept = 1'b1;
      tick();
      bus.fetch_accept = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkResetValues();
      #2;
      reset     = 1'b1;
      r0_model  = '0;
      ovf_model = 1'b0;
      tick();

      // Randomized tasks against the word-list model.
      for (int t = 0; t < 12; t++) begin
         n   = $urandom_range(1, 80);
         cap = (n < DEPTH) ? n : DEPTH;
         for (int i = 0; i < 128; i++) part_data[i] = 16'($urandom);
         runTask(n, 1'($urandom_range(0, 1)), 8'($urandom),
                 3, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cap - 1)) : -1, iters);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
